// File: rtl/prefetch_pkg.sv
// Shared types and helpers for the instruction prefetch queue.
package prefetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FULL  = 2'd2
   } pf_state_e;

   localparam int WORD_BYTES = 4;

   // Byte k of a little-endian 32-bit word.
   function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] k);
      return word[8*k +: 8];
   endfunction

endpackage

// File: rtl/prefetch_byte_fifo.sv
// Byte-granular circular FIFO: pushes and pops 0-4 bytes per cycle, exposes the
// oldest 4 bytes (zero beyond count). The caller guarantees no overflow/underflow.
module prefetch_byte_fifo
   import prefetch_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               clear_i,
   input  logic [2:0]                         push_cnt_i,
   input  logic [WORD_BYTES-1:0][7:0]         push_data_i,
   input  logic [2:0]                         pop_cnt_i,
   output logic [31:0]                        head_o,
   output logic [$clog2(DEPTH):0]             count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] head_q, tail_q;
   logic [CW-1:0] count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_q + AW'(pop_cnt_i);
         tail_q  <= tail_q + AW'(push_cnt_i);
         count_q <= count_q - CW'(pop_cnt_i) + CW'(push_cnt_i);
      end
   end

   // Storage needs no reset: reads are masked by count.
   always_ff @(posedge clk_i) begin
      if (!rst_i && !clear_i) begin
         for (int k = 0; k < WORD_BYTES; k++) begin
            if (3'(k) < push_cnt_i)
               mem_q[AW'(tail_q + AW'(k))] <= push_data_i[k];
         end
      end
   end

   always_comb begin
      head_o = '0;
      for (int k = 0; k < WORD_BYTES; k++) begin
         if (CW'(k) < count_q)
            head_o[8*k +: 8] = mem_q[AW'(head_q + AW'(k))];
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch stage: drives ROM word address, buffers returned bytes for
// the decoder. Define PREFETCH_TRACE_EN for simulation fill/flush trace output.
module prefetch_queue
   import prefetch_pkg::*;
#(
   parameter int          DEPTH         = 16,
   parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   fetch_enable,
   input  logic                   flush,
   input  logic [31:0]            flush_address,
   output logic [31:0]            mem_read_address,
   output logic                   mem_read_enable,
   input  logic [31:0]            mem_read_data,
   input  logic [2:0]             consume_count,
   output logic [31:0]            queue_data,
   output logic [$clog2(DEPTH):0] queue_count,
   output logic                   consume_error
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int LW = CW + 1;

   pf_state_e                 state_q;
   logic [31:0]               fetch_ptr_q, fetch_ptr_d;
   logic                      consume_error_q, consume_error_d;
   logic [2:0]                fill_bytes, avail, consume_eff, push_cnt, pop_cnt, lane;
   logic [LW-1:0]             fill_level;
   logic                      fill_ok;
   logic [WORD_BYTES-1:0][7:0] push_data;

   always_comb begin
      fill_bytes  = 3'(WORD_BYTES) - {1'b0, fetch_ptr_q[1:0]};
      avail       = (queue_count >= CW'(WORD_BYTES)) ? 3'(WORD_BYTES) : queue_count[2:0];
      consume_eff = (consume_count < avail) ? consume_count : avail;
      // Extra bit keeps count - consume + fill from wrapping before the compare.
      fill_level  = {1'b0, queue_count} - LW'(consume_eff) + LW'(fill_bytes);
      fill_ok     = (fill_level <= LW'(DEPTH));

      mem_read_enable = (state_q == FETCH) && fill_ok && !flush;
      push_cnt        = mem_read_enable ? fill_bytes : 3'd0;
      pop_cnt         = flush ? 3'd0 : consume_eff;

      // Skip the bytes below the (possibly unaligned) fetch pointer.
      push_data = '0;
      lane      = '0;
      for (int k = 0; k < WORD_BYTES; k++) begin
         lane = 3'(k) + {1'b0, fetch_ptr_q[1:0]};
         if (lane < 3'(WORD_BYTES))
            push_data[k] = byte_lane(mem_read_data, lane[1:0]);
      end

      if (flush)
         fetch_ptr_d = flush_address;
      else if (mem_read_enable)
         fetch_ptr_d = {fetch_ptr_q[31:2] + 30'd1, 2'b00};
      else
         fetch_ptr_d = fetch_ptr_q;

      consume_error_d = !flush && (consume_count > avail);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= IDLE;
         fetch_ptr_q     <= RESET_ADDRESS;
         consume_error_q <= 1'b0;
      end else begin
         fetch_ptr_q     <= fetch_ptr_d;
         consume_error_q <= consume_error_d;
         if (flush) begin
            if (state_q == FULL)
               state_q <= fetch_enable ? FETCH : IDLE;
         end else begin
            case (state_q)
               IDLE:        if (fetch_enable) state_q <= FETCH;
               FETCH, FULL: state_q <= !fetch_enable ? IDLE : (fill_ok ? FETCH : FULL);
               default:     state_q <= IDLE;
            endcase
         end
      end
   end

   prefetch_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i       (clock),
      .rst_i       (reset),
      .clear_i     (flush),
      .push_cnt_i  (push_cnt),
      .push_data_i (push_data),
      .pop_cnt_i   (pop_cnt),
      .head_o      (queue_data),
      .count_o     (queue_count)
   );

   assign mem_read_address = {2'b00, fetch_ptr_q[31:2]};
   assign consume_error    = consume_error_q;

`ifdef PREFETCH_TRACE_EN
   always @(posedge clock) begin
      if (!reset) begin
         if (flush)
            $display("[prefetch] flush -> 0x%08h", flush_address);
         else if (mem_read_enable)
            $display("[prefetch] fill word 0x%08h data 0x%08h bytes %0d count %0d",
                     mem_read_address, mem_read_data, fill_bytes, fill_level);
      end
   end
`else
   // Trace disabled: no simulation output.
`endif

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed self-checking bench for prefetch_queue with a combinational ROM model.
module tb_prefetch_queue;

   logic        clock = 1'b0;
   logic        reset, fetch_enable, flush;
   logic [31:0] flush_address;
   logic [31:0] mem_read_address;
   logic        mem_read_enable;
   logic [31:0] mem_read_data;
   logic [2:0]  consume_count;
   logic [31:0] queue_data;
   logic [4:0]  queue_count;
   logic        consume_error;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   function automatic logic [7:0] rom_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hC3;
   endfunction

   function automatic logic [31:0] rom_word(input logic [31:0] wi);
      logic [31:0] ba;
      ba = {wi[29:0], 2'b00};
      return {rom_byte(ba + 32'd3), rom_byte(ba + 32'd2), rom_byte(ba + 32'd1), rom_byte(ba)};
   endfunction

   assign mem_read_data = rom_word(mem_read_address);

   prefetch_queue #(.DEPTH(16), .RESET_ADDRESS(32'h0000_0000)) dut (
      .clock            (clock),
      .reset            (reset),
      .fetch_enable     (fetch_enable),
      .flush            (flush),
      .flush_address    (flush_address),
      .mem_read_address (mem_read_address),
      .mem_read_enable  (mem_read_enable),
      .mem_read_data    (mem_read_data),
      .consume_count    (consume_count),
      .queue_data       (queue_data),
      .queue_count      (queue_count),
      .consume_error    (consume_error)
   );

   // Inputs change and outputs are sampled 2 time units after the rising edge.
   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic test_reset();
      reset = 1'b1; fetch_enable = 1'b0; flush = 1'b0;
      flush_address = '0; consume_count = 3'd0;
      tick(); tick();
      reset = 1'b0;
      #1;
      checks++; if (queue_count !== 5'd0) begin failures++; $display("FAIL reset_count got %0d want 0", queue_count); end
      checks++; if (queue_data !== 32'd0) begin failures++; $display("FAIL reset_data got %h want 0", queue_data); end
      checks++; if (consume_error !== 1'b0) begin failures++; $display("FAIL reset_err got %b want 0", consume_error); end
      checks++; if (mem_read_address !== 32'd0) begin failures++; $display("FAIL reset_addr got %h want 0", mem_read_address); end
      tick();
      checks++; if (mem_read_enable !== 1'b0) begin failures++; $display("FAIL idle_mre got %b want 0", mem_read_enable); end
   endtask

   task automatic test_fill();
      fetch_enable = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         checks++; if (mem_read_address !== 32'(i)) begin failures++; $display("FAIL fill_addr%0d got %h want %h", i, mem_read_address, i); end
         checks++; if (mem_read_enable !== 1'b1) begin failures++; $display("FAIL fill_mre%0d got %b want 1", i, mem_read_enable); end
         tick();
         checks++; if (queue_count !== 5'(4*(i+1))) begin failures++; $display("FAIL fill_count%0d got %0d want %0d", i, queue_count, 4*(i+1)); end
      end
      checks++; if (mem_read_enable !== 1'b0) begin failures++; $display("FAIL full_mre got %b want 0", mem_read_enable); end
      tick();
      checks++; if (mem_read_address !== 32'd4) begin failures++; $display("FAIL full_addr got %h want 4", mem_read_address); end
      checks++; if (mem_read_enable !== 1'b0) begin failures++; $display("FAIL full_mre2 got %b want 0", mem_read_enable); end
      checks++; if (queue_data !== rom_word(32'd0)) begin failures++; $display("FAIL full_data got %h want %h", queue_data, rom_word(32'd0)); end
   endtask

   task automatic test_stream();
      // FULL: consume frees space but no fill until back in FETCH
      consume_count = 3'd4;
      #1;
      checks++; if (mem_read_enable !== 1'b0) begin failures++; $display("FAIL fullcons_mre got %b want 0", mem_read_enable); end
      tick();
      checks++; if (queue_count !== 5'd12) begin failures++; $display("FAIL fullcons_count got %0d want 12", queue_count); end
      consume_count = 3'd0;
      tick();
      checks++; if (queue_count !== 5'd16) begin failures++; $display("FAIL refill_count got %0d want 16", queue_count); end
      consume_count = 3'd4;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (queue_count !== 5'd16) begin failures++; $display("FAIL stream_count%0d got %0d want 16", i, queue_count); end
         checks++; if (queue_data !== rom_word(32'(i + 2))) begin failures++; $display("FAIL stream_data%0d got %h want %h", i, queue_data, rom_word(32'(i + 2))); end
      end
      consume_count = 3'd0;
   endtask

   task automatic test_flush_unaligned();
      logic [31:0] w;
      flush = 1'b1; flush_address = 32'h0000_0006;
      #1;
      checks++; if (mem_read_enable !== 1'b0) begin failures++; $display("FAIL flush_mre got %b want 0", mem_read_enable); end
      tick();
      flush = 1'b0;
      checks++; if (queue_count !== 5'd0) begin failures++; $display("FAIL flush_count got %0d want 0", queue_count); end
      checks++; if (mem_read_address !== 32'd1) begin failures++; $display("FAIL flush_addr got %h want 1", mem_read_address); end
      tick();
      w = rom_word(32'd1);
      checks++; if (queue_count !== 5'd2) begin failures++; $display("FAIL unal_count got %0d want 2", queue_count); end
      checks++; if (queue_data !== {16'h0, w[31:16]}) begin failures++; $display("FAIL unal_data got %h want %h", queue_data, {16'h0, w[31:16]}); end
      checks++; if (mem_read_address !== 32'd2) begin failures++; $display("FAIL unal_addr got %h want 2", mem_read_address); end
   endtask

   task automatic test_consume_error();
      consume_count = 3'd6;
      tick();
      consume_count = 3'd0;
      checks++; if (consume_error !== 1'b1) begin failures++; $display("FAIL err_set got %b want 1", consume_error); end
      checks++; if (queue_count !== 5'd4) begin failures++; $display("FAIL err_count got %0d want 4", queue_count); end
      checks++; if (queue_data !== rom_word(32'd2)) begin failures++; $display("FAIL err_data got %h want %h", queue_data, rom_word(32'd2)); end
      tick();
      checks++; if (consume_error !== 1'b0) begin failures++; $display("FAIL err_clear got %b want 0", consume_error); end
   endtask

   task automatic test_wrap();
      flush = 1'b1; flush_address = 32'hFFFF_FFFC;
      tick();
      flush = 1'b0;
      checks++; if (mem_read_address !== 32'h3FFF_FFFF) begin failures++; $display("FAIL wrap_addr0 got %h want 3fffffff", mem_read_address); end
      tick();
      checks++; if (mem_read_address !== 32'd0) begin failures++; $display("FAIL wrap_addr1 got %h want 0", mem_read_address); end
      checks++; if (queue_data !== rom_word(32'h3FFF_FFFF)) begin failures++; $display("FAIL wrap_data got %h want %h", queue_data, rom_word(32'h3FFF_FFFF)); end
   endtask

   task automatic test_flush_consume();
      tick(); tick();
      checks++; if (queue_count !== 5'd12) begin failures++; $display("FAIL pre_flush_count got %0d want 12", queue_count); end
      flush = 1'b1; flush_address = 32'h0000_0040; consume_count = 3'd4;
      tick();
      flush = 1'b0; consume_count = 3'd0;
      checks++; if (queue_count !== 5'd0) begin failures++; $display("FAIL fc_count got %0d want 0", queue_count); end
      checks++; if (consume_error !== 1'b0) begin failures++; $display("FAIL fc_err got %b want 0", consume_error); end
      checks++; if (mem_read_address !== 32'h10) begin failures++; $display("FAIL fc_addr got %h want 10", mem_read_address); end
   endtask

   task automatic test_reset_mid();
      tick();
      reset = 1'b1; consume_count = 3'd4;
      tick();
      reset = 1'b0; consume_count = 3'd0;
      #1;
      checks++; if (queue_count !== 5'd0) begin failures++; $display("FAIL rmid_count got %0d want 0", queue_count); end
      checks++; if (mem_read_address !== 32'd0) begin failures++; $display("FAIL rmid_addr got %h want 0", mem_read_address); end
      checks++; if (mem_read_enable !== 1'b0) begin failures++; $display("FAIL rmid_idle got %b want 0", mem_read_enable); end
      tick();
      checks++; if (mem_read_enable !== 1'b1) begin failures++; $display("FAIL rmid_fetch got %b want 1", mem_read_enable); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_stream();
      test_flush_unaligned();
      test_consume_error();
      test_wrap();
      test_flush_consume();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prefetch_queue.md
Name: prefetch_queue

Overview:
- Instruction prefetch stage directly upstream of the simulation ROM: drives its word read address, captures the returned 32-bit word, and buffers instruction bytes in a byte-granular FIFO for the decoder.
- Supports decoder consumption of 0–4 bytes per cycle and flush/redirect to an arbitrary, possibly unaligned, byte address (jump/branch target).

Parameters:
- DEPTH, 16, queue capacity in bytes; power of two, ≥8.
- RESET_ADDRESS, 32'h0000_0000, byte address fetched first after reset.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- fetch_enable  input  1  allows fetching; low holds state (queue still drains).
- flush  input  1  discard queue, redirect fetch.
- flush_address  input  32  byte address of redirect target.
- mem_read_address  output  32  word index to ROM: {2'b00, fetch_ptr[31:2]}.
- mem_read_enable  output  1  high in cycles where the returned word is written.
- mem_read_data  input  32  ROM word; combinational same-cycle return; little-endian, byte k = bits [8k+7:8k].
- consume_count  input  3  bytes removed by decoder this cycle.
- queue_data  output  32  oldest 4 bytes; byte 0 = oldest in bits [7:0]; bytes at or beyond queue_count read 0.
- queue_count  output  $clog2(DEPTH)+1  valid bytes, 0..DEPTH.
- consume_error  output  1  registered; consume_count exceeded min(4, queue_count) last cycle.

Behaviour:
- Reset: fetch_ptr = RESET_ADDRESS, queue empty, queue_count = 0, queue_data = 0, consume_error = 0, state = IDLE. Reset overrides flush, fill and consume in the same cycle.
- State IDLE → FETCH when fetch_enable = 1. FETCH → IDLE when fetch_enable = 0.
- In FETCH, compute these per cycle:
  - fill_bytes = 4 − fetch_ptr[1:0].
  - consume_eff = min(consume_count, 4, queue_count).
  - Fill when (queue_count − consume_eff) + fill_bytes ≤ DEPTH.
- FETCH → FULL when the fill condition fails. FULL → FETCH when it holds. Re-evaluated every cycle.
- mem_read_enable = (state == FETCH) and fill condition, with no flush. It is combinational from state, queue_count, consume_count and fetch_ptr.
- Fill on the edge:
  - Append bytes fetch_ptr[1:0]..3 of mem_read_data in ascending order.
  - fetch_ptr ← {fetch_ptr[31:2]+1, 2'b00}, wrapping 0xFFFF_FFFC → 0x0000_0000.
- Latency: word presented at edge N appears in queue_data after edge N when the queue was empty. Throughput is 4 bytes/cycle sustained.
- Consume and fill in the same cycle: new queue_count = queue_count − consume_eff + fill_bytes. Consume happens at the head, fill at the tail.
- Consume when not in FETCH: the queue still drains in IDLE/FULL.
- Flush has priority over consume and fill:
  - Queue is cleared (queue_count = 0 next cycle).
  - fetch_ptr ← flush_address.
  - No fill that cycle; state unchanged unless FULL, which goes to FETCH (if fetch_enable) else IDLE.
  - consume_error is not raised during flush.
- First fill after an unaligned flush delivers only the tail bytes of the word. Subsequent fills are aligned.
- consume_count > min(4, queue_count): clamp to consume_eff and set consume_error for one cycle.
- Storage: circular byte buffer with head/tail pointers of width $clog2(DEPTH), wrapping modulo DEPTH. queue_count is stored explicitly so full and empty are unambiguous.

Optional Feature:
- PREFETCH_TRACE_EN defined: on every fill edge, $display of the cycle's word index, the word, fill_bytes and the new queue_count; on flush, $display of the target address. Simulation only.
- Undefined: no display statements; logic identical.

Decomposition:
- Package prefetch_pkg:
  - state enum typedef (IDLE, FETCH, FULL).
  - WORD_BYTES = 4 constant.
  - function byte_lane(word, k) returning byte k of a little-endian word.
- One sub-module, prefetch_byte_fifo:
  - Inputs: multi-byte push (0–4 bytes), multi-byte pop (0–4), clear.
  - Outputs: head window of 4 bytes, count.
  - prefetch_queue keeps fetch_ptr, the state machine and the fill/consume arithmetic.

Test Plan:
- Reset, fetch_enable = 1, consume 0:
  - mem_read_address 0, 1, 2, 3 on successive cycles.
  - queue_count 4, 8, 12, 16.
  - Then FULL, mem_read_enable = 0, address stays 4.
- Full queue, consume 4 every cycle → one fill per cycle; queue_count stays 16; queue_data equals successive ROM words in order.
- Flush to 0x0000_0006:
  - Next cycle queue_count = 0, mem_read_address = 1.
  - After the following edge, queue_count = 2 and queue_data[15:0] = mem[1][31:16].
  - Next address is 2.
- Flush to 0xFFFF_FFFC:
  - Address 0x3FFF_FFFF, then 0x0000_0000 (pointer wrap).
- queue_count = 2, consume_count = 6 → queue_count 0 (plus any fill), consume_error = 1 for one cycle.
- Flush and consume 4 in the same cycle with the queue at 12 → queue_count 0, no error.
- Reset asserted mid-stream → next cycle queue_count = 0, address = RESET_ADDRESS>>2, state IDLE.
